mask_encoder: RTL and testbench

Sequential mask-to-address encoder: accepts a SIZE-bit one-hot/multi-hot mask and emits up to K packed BIT-wide addresses of its set bits, lowest index first, one bit resolved per clock. It is the inverse of the team's Decoder block. Its packed `out_addr` bus has the same K×BIT layout as the Decoder's `generated_addr` input, so masks can be round-tripped through the pair. Valid/ready handshakes sit on both sides so it can be placed between a mask producer and an address consumer.

---
 rtl/mask_encoder.sv | 147 ++++++++++++++
 tb/tb_mask_encoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mask_encoder.sv
// mask_encoder: sequential mask-to-address encoder.
// Accepts a SIZE-bit mask and emits up to K packed BIT-wide addresses of its
// set bits, lowest index first, one bit resolved per clock. The out_addr
// layout matches the Decoder's generated_addr input.
// Optional feature macro: MASK_ENCODER_PAD_REPEAT_EN -- when defined, unused
// chunks are filled with the last written address on SCAN->DONE so that the
// Decoder regenerates the input mask for up to K set bits.
module mask_encoder #(
  parameter int SIZE = 8,
  parameter int K    = 4,
  parameter int BIT  = $clog2(SIZE),
  parameter int CW   = $clog2(K + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K*BIT-1:0] out_addr,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [SIZE-1:0]  work;
  logic [SIZE-1:0]  work_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [K*BIT-1:0] addr;
  logic [K*BIT-1:0] addr_next;
  logic             ovf;
  logic             ovf_next;
  logic [BIT-1:0]   low_idx;
  logic             low_found;

`ifdef MASK_ENCODER_PAD_REPEAT_EN
  logic [BIT-1:0]   last_addr;
`endif

  // Priority encoder: index of the lowest set bit of the working mask.
  always_comb begin
    low_idx   = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (!low_found && work[i]) begin
        low_idx   = BIT'(i);
        low_found = 1'b1;
      end
    end
  end

`ifdef MASK_ENCODER_PAD_REPEAT_EN
  // Most recently written chunk (chunk cnt-1), used as the padding value.
  always_comb begin
    last_addr = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (CW'(i + 1) == cnt) last_addr = addr[i*BIT +: BIT];
    end
  end
`endif

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_next = state;
    work_next  = work;
    cnt_next   = cnt;
    addr_next  = addr;
    ovf_next   = ovf;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_next  = in_mask;
          cnt_next   = '0;
          addr_next  = '0;
          ovf_next   = 1'b0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (work == '0) begin
          state_next = DONE;
`ifdef MASK_ENCODER_PAD_REPEAT_EN
          // cnt==K leaves no chunk at or above cnt, so only 1..K-1 pads.
          if (cnt != '0) begin
            for (int unsigned i = 0; i < K; i++) begin
              if (CW'(i) >= cnt) addr_next[i*BIT +: BIT] = last_addr;
            end
          end
`endif
        end else if (cnt == CW'(K)) begin
          ovf_next   = 1'b1;
          state_next = DONE;
        end else begin
          for (int unsigned i = 0; i < K; i++) begin
            if (CW'(i) == cnt) addr_next[i*BIT +: BIT] = low_idx;
          end
          // Clearing the lowest set bit is the same as clearing work[low_idx].
          work_next = work & (work - SIZE'(1));
          cnt_next  = cnt + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath registers: working mask, chunk counter, addresses, overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
      addr <= '0;
      ovf  <= 1'b0;
    end else begin
      work <= work_next;
      cnt  <= cnt_next;
      addr <= addr_next;
      ovf  <= ovf_next;
    end
  end

  assign out_addr     = addr;
  assign out_count    = cnt;
  assign out_overflow = ovf;

endmodule

// File: tb/tb_mask_encoder.sv
// Scoreboard testbench for mask_encoder (SIZE=8, K=4, BIT=3).
// Builds with or without MASK_ENCODER_PAD_REPEAT_EN; expected addresses follow.
module tb_mask_encoder;

  localparam int SIZE = 8;
  localparam int K    = 4;
  localparam int BIT  = 3;
  localparam int CW   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [SIZE-1:0]  in_mask = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [K*BIT-1:0] out_addr;
  logic [CW-1:0]    out_count;
  logic             out_overflow;

  typedef struct {
    logic [K*BIT-1:0] addr;
    logic [CW-1:0]    count;
    logic             ovf;
    int               lat;
    int               acc;
    logic [SIZE-1:0]  mask;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;
  int   first_seen = 0;

  mask_encoder #(.SIZE(SIZE), .K(K), .BIT(BIT), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_count(out_count), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [K*BIT-1:0] a, input logic [CW-1:0] c,
                              input logic o, input int lat);
    exp_t e;
    e.addr = a; e.count = c; e.ovf = o; e.lat = lat; e.acc = 0; e.mask = '0;
    return e;
  endfunction

  // Behavioural reference used for the random masks.
  function automatic exp_t model(input logic [SIZE-1:0] m);
    exp_t e;
    int n = 0;
    int total = 0;
    e = mk('0, '0, 1'b0, 0);
    e.mask = m;
    for (int b = 0; b < SIZE; b++) begin
      if (m[b]) begin
        total++;
        if (n < K) begin
          e.addr[n*BIT +: BIT] = BIT'(b);
          n++;
        end
      end
    end
    e.count = CW'(n);
    e.ovf   = (total > K);
    e.lat   = (total > K) ? K + 1 : total + 1;
`ifdef MASK_ENCODER_PAD_REPEAT_EN
    if (n >= 1 && n < K)
      for (int i = n; i < K; i++) e.addr[i*BIT +: BIT] = e.addr[(n-1)*BIT +: BIT];
`endif
    return e;
  endfunction

  function automatic logic [SIZE-1:0] decode(input logic [K*BIT-1:0] a);
    logic [SIZE-1:0] m = '0;
    for (int i = 0; i < K; i++) m[a[i*BIT +: BIT]] = 1'b1;
    return m;
  endfunction

  // Issue one mask; inputs change 1 time unit after the rising edge.
  task automatic send(input logic [SIZE-1:0] m, input exp_t e, input bit track);
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: actual=in_ready low required=in_ready high");
      return;
    end
    in_mask  = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.acc  = cyc;
    e.mask = m;
    if (track) sb.push_back(e);
  endtask

  // Monitor: compares every consumed result with the scoreboard head.
  always @(negedge clk) begin : monitor
    int   fs;
    exp_t e;
    fs = (out_valid && !prev_valid) ? cyc : first_seen;
    first_seen <= fs;
    prev_valid <= out_valid;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: actual=addr %0h count %0d required=no output",
                 out_addr, out_count);
      end else begin
        e = sb.pop_front();
        check("out_addr", 32'(out_addr), 32'(e.addr));
        check("out_count", 32'(out_count), 32'(e.count));
        check("out_overflow", 32'(out_overflow), 32'(e.ovf));
        check("latency", 32'(fs - e.acc), 32'(e.lat));
`ifdef MASK_ENCODER_PAD_REPEAT_EN
        if (e.count != '0) check("roundtrip", 32'(decode(out_addr)), 32'(e.mask));
`endif
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [K*BIT-1:0] a25, a80, a02;
    logic [SIZE-1:0]  rm;
    logic [SIZE-1:0]  one;
    int               t;
`ifdef MASK_ENCODER_PAD_REPEAT_EN
    a25 = 12'hB50; a80 = 12'hFFF; a02 = 12'h249;
`else
    a25 = 12'h150; a80 = 12'h007; a02 = 12'h001;
`endif
    one = 8'h01;

    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_overflow", 32'(out_overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with out_ready held high
    out_ready = 1'b1;
    send(8'h25, mk(a25, 3'd3, 1'b0, 4), 1'b1);
    send(8'hFF, mk(12'h688, 3'd4, 1'b1, 5), 1'b1);
    send(8'h00, mk(12'h000, 3'd0, 1'b0, 1), 1'b1);
    send(8'hF0, mk(12'hFAC, 3'd4, 1'b0, 5), 1'b1);
    send(8'h1F, mk(12'h688, 3'd4, 1'b1, 5), 1'b1);

    // Back-pressure: hold DONE for 3 cycles while pulsing in_valid
    t = 0;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    out_ready = 1'b0;
    send(8'h80, mk(a80, 3'd1, 1'b0, 2), 1'b1);
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    check("bp_reached_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      in_mask  = 8'h01;
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_addr", 32'(out_addr), 32'(a80));
      check("bp_out_count", 32'(out_count), 32'd1);
      check("bp_out_overflow", 32'(out_overflow), 32'd0);
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    // A queued pulse would appear here as an extra output
    send(8'h00, mk(12'h000, 3'd0, 1'b0, 1), 1'b1);

    // Reset during SCAN of 8'hF0
    send(8'hF0, mk('0, '0, 1'b0, 0), 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_addr", 32'(out_addr), 32'd0);
    check("mid_rst_out_count", 32'(out_count), 32'd0);
    check("mid_rst_out_overflow", 32'(out_overflow), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h02, mk(a02, 3'd1, 1'b0, 2), 1'b1);

    // Random masks with 1..4 set bits
    for (int n = 0; n < 200; n++) begin
      int k;
      k  = $urandom_range(1, K);
      rm = '0;
      while ($countones(rm) < k) rm = rm | (one << $urandom_range(0, SIZE - 1));
      send(rm, model(rm), 1'b1);
    end

    // Drain
    t = 0;
    while (sb.size() != 0 && t < 1000) begin @(posedge clk); #1; t++; end
    check("drain_pending", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
